conway_serial_grid: RTL and testbench

CONWAY_SERIAL_GRID -- requirements
Module: conway_serial_grid

---
 rtl/conway_pkg.sv | 39 +++
 rtl/conway_if.sv | 32 +++
 rtl/conway_next_gen.sv | 64 ++++++
 rtl/conway_serial_grid.sv | 157 +++++++++++++++
 tb/tb_conway_serial_grid.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conway_pkg.sv
// ============================================================================
//  Module      : conway_pkg
//  Description : Shared types for the serial Game-of-Life grid: the host
//                mode encoding, the controller state encoding and a helper
//                for counter widths.
//  Options     : CONWAY_WRAP_EN (toroidal neighbour lookup in conway_next_gen)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conway_pkg;

   // Host command presented on the mode port.
   typedef enum logic [1:0] {
      MODE_IDLE   = 2'b00,
      MODE_LOAD   = 2'b01,
      MODE_RUN    = 2'b10,
      MODE_OUTPUT = 2'b11
   } mode_e;

   // Controller state.
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_LOAD_FULL = 3'd2,
      S_RUN       = 3'd3,
      S_HALT      = 3'd4,
      S_OUTPUT    = 3'd5,
      S_OUT_END   = 3'd6
   } state_e;

   // Width of an index able to address n items (at least one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/conway_if.sv
// ============================================================================
//  Module      : conway_if
//  Description : Host-side signal bundle of the serial Game-of-Life grid.
//                The host drives data_in/mode and observes the rest.
//  Options     : none
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conway_if #(
   parameter int GEN_W = 16
) ();
   logic             data_in;
   logic [1:0]       mode;
   logic             data_out;
   logic             load_done;
   logic             out_done;
   logic             stable;
   logic [GEN_W-1:0] gen_count;

   modport master (
      output data_in, mode,
      input  data_out, load_done, out_done, stable, gen_count
   );

   modport slave (
      input  data_in, mode,
      output data_out, load_done, out_done, stable, gen_count
   );
endinterface

`default_nettype wire

// File: rtl/conway_next_gen.sv
// ============================================================================
//  Module      : conway_next_gen
//  Description : Combinational B3/S23 next-generation array. Each cell counts
//                its eight neighbours; off-grid neighbours read as dead unless
//                toroidal wrap is enabled.
//  Options     : CONWAY_WRAP_EN - neighbour row/col taken modulo grid size
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conway_next_gen #(
   parameter int GRID_WIDTH  = 8,
   parameter int GRID_HEIGHT = 8
) (
   input  logic [GRID_WIDTH*GRID_HEIGHT-1:0] i_grid,
   output logic [GRID_WIDTH*GRID_HEIGHT-1:0] o_next
);

   for (genvar r = 0; r < GRID_HEIGHT; r++) begin : g_row
      for (genvar c = 0; c < GRID_WIDTH; c++) begin : g_col
         logic [8:0] w_nb;
         logic [3:0] w_cnt;

         // 3x3 window around (r,c); k = 4 is the cell itself and never counts.
         for (genvar k = 0; k < 9; k++) begin : g_nb
            localparam int c_rr = r + (k / 3) - 1;
            localparam int c_cc = c + (k % 3) - 1;
            if (k == 4) begin : g_self
               assign w_nb[k] = 1'b0;
            end
`ifdef CONWAY_WRAP_EN
            else begin : g_wrap
               localparam int c_wr = (c_rr + GRID_HEIGHT) % GRID_HEIGHT;
               localparam int c_wc = (c_cc + GRID_WIDTH) % GRID_WIDTH;
               assign w_nb[k] = i_grid[c_wr*GRID_WIDTH + c_wc];
            end
`else
            else if (c_rr < 0 || c_rr >= GRID_HEIGHT ||
                     c_cc < 0 || c_cc >= GRID_WIDTH) begin : g_edge
               assign w_nb[k] = 1'b0;
            end
            else begin : g_inner
               assign w_nb[k] = i_grid[c_rr*GRID_WIDTH + c_cc];
            end
`endif
         end

         // Population count of the live neighbours.
         always_comb begin
            w_cnt = '0;
            for (int j = 0; j < 9; j++) begin
               w_cnt = w_cnt + {3'b000, w_nb[j]};
            end
         end

         // Birth on exactly three, survival on two or three.
         assign o_next[r*GRID_WIDTH + c] = (w_cnt == 4'd3) |
                                           (i_grid[r*GRID_WIDTH + c] & (w_cnt == 4'd2));
      end
   end

endmodule

`default_nettype wire

// File: rtl/conway_serial_grid.sv
// ============================================================================
//  Module      : conway_serial_grid
//  Description : Game-of-Life grid with serial load and serial dump. The host
//                selects idle/load/run/output through mode; the action for a
//                mode happens on every clock edge that samples it. Load and
//                run act on the entry edge itself (first bit written, first
//                generation computed); output uses the entry edge to clear the
//                index so data_out is a pure function of registered state.
//  Options     : CONWAY_WRAP_EN - toroidal neighbourhood (see conway_next_gen)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conway_serial_grid #(
   parameter int GRID_WIDTH  = 8,
   parameter int GRID_HEIGHT = 8,
   parameter int GEN_W       = 16
) (
   input  logic     clk,
   input  logic     reset,
   conway_if.slave  bus
);
   import conway_pkg::*;

   localparam int                   c_n     = GRID_WIDTH * GRID_HEIGHT;
   localparam int                   c_idx_w = idx_width(c_n);
   localparam logic [c_idx_w-1:0]   c_last  = c_idx_w'(c_n - 1);

   state_e              state_q, state_d;
   logic [c_n-1:0]      grid_q, grid_d;
   logic [c_idx_w-1:0]  bit_cnt_q, bit_cnt_d;
   logic [c_idx_w-1:0]  out_idx_q, out_idx_d;
   logic [GEN_W-1:0]    gen_count_q, gen_count_d;
   logic                stable_q, stable_d;
   logic                load_done_q, load_done_d;
   logic                out_done_q, out_done_d;

   logic [c_n-1:0]      w_next_grid;
   mode_e               w_mode;
   logic                w_load_entry;
   logic [c_idx_w-1:0]  w_load_idx;

   conway_next_gen #(
      .GRID_WIDTH  (GRID_WIDTH),
      .GRID_HEIGHT (GRID_HEIGHT)
   ) u_next_gen (
      .i_grid (grid_q),
      .o_next (w_next_grid)
   );

   assign w_mode       = mode_e'(bus.mode);
   // A load that starts from any non-load state begins again at bit 0.
   assign w_load_entry = (state_q != S_LOAD) && (state_q != S_LOAD_FULL);
   assign w_load_idx   = w_load_entry ? '0 : bit_cnt_q;

   // Next-state, grid update and counter logic driven by the sampled mode.
   always_comb begin
      state_d     = state_q;
      grid_d      = grid_q;
      bit_cnt_d   = bit_cnt_q;
      out_idx_d   = out_idx_q;
      gen_count_d = gen_count_q;
      stable_d    = stable_q;
      load_done_d = 1'b0;
      out_done_d  = 1'b0;

      case (w_mode)
         MODE_IDLE: begin
            state_d = S_IDLE;
         end

         MODE_LOAD: begin
            if (state_q != S_LOAD_FULL) begin
               if (w_load_entry) begin
                  stable_d    = 1'b0;
                  gen_count_d = '0;
               end
               // First serial bit lands in the highest-numbered cell.
               grid_d[c_last - w_load_idx] = bus.data_in;
               if (w_load_idx == c_last) begin
                  bit_cnt_d   = w_load_idx;
                  load_done_d = 1'b1;
                  state_d     = S_LOAD_FULL;
               end else begin
                  bit_cnt_d   = w_load_idx + 1'b1;
                  state_d     = S_LOAD;
               end
            end
         end

         MODE_RUN: begin
            if (state_q != S_HALT) begin
               if (w_next_grid == grid_q) begin
                  stable_d = 1'b1;
                  state_d  = S_HALT;
               end else begin
                  grid_d  = w_next_grid;
                  state_d = S_RUN;
                  if (gen_count_q != '1) begin
                     gen_count_d = gen_count_q + 1'b1;
                  end
               end
            end
         end

         MODE_OUTPUT: begin
            if (state_q == S_OUTPUT) begin
               if (out_idx_q == c_last) begin
                  out_done_d = 1'b1;
                  state_d    = S_OUT_END;
               end else begin
                  out_idx_d  = out_idx_q + 1'b1;
               end
            end else if (state_q != S_OUT_END) begin
               out_idx_d = '0;
               state_d   = S_OUTPUT;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, grid and counter registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         grid_q      <= '0;
         bit_cnt_q   <= '0;
         out_idx_q   <= '0;
         gen_count_q <= '0;
         stable_q    <= 1'b0;
         load_done_q <= 1'b0;
         out_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         grid_q      <= grid_d;
         bit_cnt_q   <= bit_cnt_d;
         out_idx_q   <= out_idx_d;
         gen_count_q <= gen_count_d;
         stable_q    <= stable_d;
         load_done_q <= load_done_d;
         out_done_q  <= out_done_d;
      end
   end

   assign bus.data_out  = (state_q == S_OUTPUT) ? grid_q[c_last - out_idx_q] : 1'b0;
   assign bus.load_done = load_done_q;
   assign bus.out_done  = out_done_q;
   assign bus.stable    = stable_q;
   assign bus.gen_count = gen_count_q;

endmodule

`default_nettype wire

// File: tb/tb_conway_serial_grid.sv
// ============================================================================
//  Module      : tb_conway_serial_grid
//  Description : Self-checking bench for conway_serial_grid on an 8x8 grid
//                with a 4-bit generation counter, using a plain-arithmetic
//                Game-of-Life reference model.
//  Options     : CONWAY_WRAP_EN - reference model wraps toroidally as well
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conway_serial_grid;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int N  = W * H;
   localparam int GW = 4;
   localparam int GEN_MAX = (1 << GW) - 1;

   logic clk = 1'b0;
   logic reset;

   conway_if #(.GEN_W(GW)) bus ();

   conway_serial_grid #(
      .GRID_WIDTH  (W),
      .GRID_HEIGHT (H),
      .GEN_W       (GW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   int          load_pulses = 0;
   int          out_pulses = 0;
   logic [63:0] m_grid = '0;
   int          m_gen = 0;
   bit          m_halt = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference Game-of-Life step computed cell by cell from the rules.
   function automatic logic [63:0] life(input logic [63:0] g);
      logic [63:0] n;
      int cnt, rr, cc;
      n = '0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  rr = r + dr;
                  cc = c + dc;
`ifdef CONWAY_WRAP_EN
                  rr = (rr + H) % H;
                  cc = (cc + W) % W;
                  if (!(dr == 0 && dc == 0)) cnt += int'(g[rr*W + cc]);
`else
                  if (!(dr == 0 && dc == 0) && rr >= 0 && rr < H && cc >= 0 && cc < W)
                     cnt += int'(g[rr*W + cc]);
`endif
               end
            end
            n[r*W + c] = (cnt == 3) || (g[r*W + c] && cnt == 2);
         end
      end
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.load_done === 1'b1) load_pulses++;
      if (bus.out_done === 1'b1) out_pulses++;
   endtask

   task automatic load_full(input logic [63:0] g);
      bus.mode = 2'b01;
      for (int i = 0; i < N; i++) begin
         bus.data_in = g[N-1-i];
         tick();
         if (i == 0) begin
            check("load_clr_stable", 64'(bus.stable), 64'd0);
            check("load_clr_gen", 64'(bus.gen_count), 64'd0);
         end
         if (i < N-1) check("load_done_early", 64'(bus.load_done), 64'd0);
      end
      check("load_done_pulse", 64'(bus.load_done), 64'd1);
      bus.data_in = ~g[0];
      tick();
      check("load_done_once", 64'(bus.load_done), 64'd0);
      bus.mode = 2'b00;
      bus.data_in = 1'b0;
      tick();
      m_grid = g;
      m_gen  = 0;
      m_halt = 1'b0;
      check("load_grid", dut.grid_q, m_grid);
   endtask

   task automatic dump(output logic [63:0] s);
      s = '0;
      bus.mode = 2'b11;
      tick();
      for (int i = 0; i < N; i++) begin
         s[N-1-i] = bus.data_out;
         check("out_done_early", 64'(bus.out_done), 64'd0);
         tick();
      end
      check("out_done_pulse", 64'(bus.out_done), 64'd1);
      check("data_out_end", 64'(bus.data_out), 64'd0);
      tick();
      check("out_done_once", 64'(bus.out_done), 64'd0);
      check("data_out_end_hold", 64'(bus.data_out), 64'd0);
      bus.mode = 2'b00;
      tick();
   endtask

   task automatic run_steps(input int n);
      logic [63:0] nx;
      bus.mode = 2'b10;
      for (int i = 0; i < n; i++) begin
         tick();
         if (!m_halt) begin
            nx = life(m_grid);
            if (nx == m_grid) m_halt = 1'b1;
            else begin
               m_grid = nx;
               if (m_gen != GEN_MAX) m_gen++;
            end
         end
         check("run_grid", dut.grid_q, m_grid);
         check("run_gen", 64'(bus.gen_count), 64'(m_gen));
         check("run_stable", 64'(bus.stable), 64'(m_halt));
         check("run_data_out", 64'(bus.data_out), 64'd0);
      end
      bus.mode = 2'b00;
      tick();
      check("idle_grid", dut.grid_q, m_grid);
      check("idle_gen", 64'(bus.gen_count), 64'(m_gen));
   endtask

   initial begin
      logic [63:0] s, s2, g, pat;
      int lp, op;

      // Reset state
      reset = 1'b1;
      bus.mode = 2'b00;
      bus.data_in = 1'b0;
      tick();
      tick();
      check("rst_grid", dut.grid_q, 64'd0);
      check("rst_gen", 64'(bus.gen_count), 64'd0);
      check("rst_stable", 64'(bus.stable), 64'd0);
      check("rst_load_done", 64'(bus.load_done), 64'd0);
      check("rst_out_done", 64'(bus.out_done), 64'd0);
      check("rst_data_out", 64'(bus.data_out), 64'd0);
      reset = 1'b0;
      tick();

      // Fixed pattern round trip
      pat = 64'hA5A5_5A5A_0F0F_F0F0;
      load_pulses = 0;
      out_pulses = 0;
      load_full(pat);
      dump(s);
      check("dump_pattern", s, pat);
      check("load_pulse_count", 64'(load_pulses), 64'd1);
      check("out_pulse_count", 64'(out_pulses), 64'd1);

      // Blinker oscillates; then the 4-bit counter saturates
      g = (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 29);
      load_full(g);
      run_steps(3);
      check("blinker_vertical", dut.grid_q, (64'd1 << 20) | (64'd1 << 28) | (64'd1 << 36));
      check("blinker_gen3", 64'(bus.gen_count), 64'd3);
      check("blinker_stable", 64'(bus.stable), 64'd0);
      run_steps(15);
      check("gen_saturated", 64'(bus.gen_count), 64'(GEN_MAX));

      // Block still life halts immediately and stays halted
      g = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9);
      load_full(g);
      run_steps(1);
      check("block_stable", 64'(bus.stable), 64'd1);
      check("block_gen", 64'(bus.gen_count), 64'd0);
      check("block_grid", dut.grid_q, g);
      run_steps(2);
      check("block_stable_hold", 64'(bus.stable), 64'd1);
`ifdef CONWAY_WRAP_EN
      g = (64'd1 << 7) | (64'd1 << 0) | (64'd1 << 15) | (64'd1 << 8);
      load_full(g);
      run_steps(1);
      check("wrap_block_stable", 64'(bus.stable), 64'd1);
`endif

      // Glider from the top-left corner
      g = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) | (64'd1 << 17) | (64'd1 << 18);
      load_full(g);
      run_steps(20);

      // Random soups
      for (int t = 0; t < 3; t++) begin
         g = {$urandom, $urandom};
         load_full(g);
         run_steps(int'($urandom_range(3, 12)));
         dump(s);
         check("random_dump", s, m_grid);
      end

      // Load aborted after 10 bits keeps the partial write, no load_done
      lp = load_pulses;
      g = {$urandom, $urandom};
      bus.mode = 2'b01;
      for (int i = 0; i < 10; i++) begin
         bus.data_in = g[N-1-i];
         tick();
         m_grid[N-1-i] = g[N-1-i];
      end
      bus.mode = 2'b00;
      tick();
      check("abort_no_load_done", 64'(load_pulses), 64'(lp));
      dump(s);
      check("abort_partial_grid", s, m_grid);
      g = {$urandom, $urandom};
      load_full(g);
      check("reload_one_pulse", 64'(load_pulses), 64'(lp + 1));
      dump(s);
      dump(s2);
      check("dump_repeat_same", s2, s);
      check("dump_repeat_model", s, m_grid);

      // Leaving load on the final bit's edge: last cell untouched, no pulse
      lp = load_pulses;
      g = {$urandom, $urandom};
      bus.mode = 2'b01;
      for (int i = 0; i < N-1; i++) begin
         bus.data_in = g[N-1-i];
         tick();
         m_grid[N-1-i] = g[N-1-i];
      end
      bus.data_in = ~m_grid[0];
      bus.mode = 2'b00;
      tick();
      tick();
      check("late_abort_no_load_done", 64'(load_pulses), 64'(lp));
      dump(s);
      check("late_abort_grid", s, m_grid);

      // Output aborted at index 20 restarts at 0; abort at last index gives no pulse
      op = out_pulses;
      bus.mode = 2'b11;
      tick();
      repeat (20) tick();
      bus.mode = 2'b00;
      tick();
      check("out_abort_data_out", 64'(bus.data_out), 64'd0);
      dump(s);
      check("out_restart_dump", s, m_grid);
      op = out_pulses;
      bus.mode = 2'b11;
      tick();
      repeat (N-1) tick();
      bus.mode = 2'b00;
      tick();
      tick();
      check("out_late_abort_no_pulse", 64'(out_pulses), 64'(op));

      // Asynchronous reset in the middle of a dump
      bus.mode = 2'b11;
      tick();
      repeat (30) tick();
      #2;
      reset = 1'b1;
      #1;
      check("midrst_data_out", 64'(bus.data_out), 64'd0);
      check("midrst_grid", dut.grid_q, 64'd0);
      check("midrst_gen", 64'(bus.gen_count), 64'd0);
      #3;
      reset = 1'b0;
      m_grid = '0;
      op = out_pulses;
      tick();
      for (int i = 0; i < N; i++) begin
         check("postrst_data_out", 64'(bus.data_out), 64'd0);
         tick();
      end
      check("postrst_out_done", 64'(out_pulses), 64'(op + 1));
      bus.mode = 2'b00;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
